// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC/IF-ID/ID-EX enable and flush sequencing for branches, load-use and multicycle EX ops.
// Optional perf counters built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_W      = 4,
    parameter int MC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_branch_taken,
    input  logic             mc_start,
    input  logic             mc_done,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mc_err,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
);
    localparam int CW = $clog2(MC_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MC_TIMEOUT - 1);

    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic          err_nxt;
    logic          lu;

    assign lu = ex_mem_read & ex_reg_write & (ex_rd != '0) &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        err_nxt    = mc_err;
        if (rst) begin
            {pc_en, ifid_en, idex_en, ifid_flush, idex_flush} = 5'b00011;
        end else if (state == RUN) begin
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (mc_start) begin
                if (!mc_done) begin
                    {pc_en, ifid_en, idex_en} = 3'b000;
                    state_nxt = MC_WAIT;
                    wait_nxt  = '0;
                end
            end else if (lu) begin
                {pc_en, ifid_en, idex_flush} = 3'b001;
            end
        end else if (mc_done) begin
            state_nxt = RUN;
        end else if (wait_cnt == LAST) begin
            // watchdog: release the pipe and squash the stuck op
            idex_flush = 1'b1;
            err_nxt    = 1'b1;
            state_nxt  = RUN;
        end else begin
            {pc_en, ifid_en, idex_en} = 3'b000;
            wait_nxt = wait_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mc_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mc_err   <= err_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (state == RUN && ex_branch_taken && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, corner sequences and random stimulus against a behavioural model.
// Two instances share stimulus: default MC_TIMEOUT=64 and a short MC_TIMEOUT=4 for watchdog cases.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int T0 = 64;
    localparam int T1 = 4;

    logic clk = 1'b0;
    logic rst, us1, us2, mr, rw, br, ms, md;
    logic [3:0] rs1, rs2, rd;
    logic [1:0] pc, ifid, idex, ifl, idfl, err;
    logic [15:0] sc [2];
    logic [15:0] fc [2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(4), .MC_TIMEOUT(T0)) dut (
        .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs1(us1), .id_uses_rs2(us2),
        .ex_rd(rd), .ex_mem_read(mr), .ex_reg_write(rw), .ex_branch_taken(br),
        .mc_start(ms), .mc_done(md), .pc_en(pc[0]), .ifid_en(ifid[0]), .idex_en(idex[0]),
        .ifid_flush(ifl[0]), .idex_flush(idfl[0]), .mc_err(err[0]),
        .stall_cnt(sc[0]), .flush_cnt(fc[0]));

    pipe_hazard_ctrl #(.REG_W(4), .MC_TIMEOUT(T1)) dut4 (
        .clk(clk), .rst(rst), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs1(us1), .id_uses_rs2(us2),
        .ex_rd(rd), .ex_mem_read(mr), .ex_reg_write(rw), .ex_branch_taken(br),
        .mc_start(ms), .mc_done(md), .pc_en(pc[1]), .ifid_en(ifid[1]), .idex_en(idex[1]),
        .ifid_flush(ifl[1]), .idex_flush(idfl[1]), .mc_err(err[1]),
        .stall_cnt(sc[1]), .flush_cnt(fc[1]));

    typedef struct {
        bit busy;
        int waited;
        bit err;
        int stalls;
        int flushes;
    } mstate_t;

    typedef struct {
        logic       rst;
        logic [3:0] rs1, rs2;
        logic       us1, us2;
        logic [3:0] rd;
        logic       mr, rw, br, ms, md;
        logic [4:0] want;
    } vec_t;

    mstate_t m [2];
    int tmo [2] = '{T0, T1};
    int pass_cnt = 0;
    int total = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit hazard();
        return mr && rw && rd != 0 && ((us1 && rs1 == rd) || (us2 && rs2 == rd));
    endfunction

    // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush}
    function automatic logic [4:0] expect_out(mstate_t s, int t);
        if (rst) return 5'b00011;
        if (s.busy) begin
            if (md) return 5'b11100;
            if (s.waited == t - 1) return 5'b11101;
            return 5'b00000;
        end
        if (br) return 5'b11111;
        if (ms) return md ? 5'b11100 : 5'b00000;
        if (hazard()) return 5'b00101;
        return 5'b11100;
    endfunction

    function automatic mstate_t advance(mstate_t s, int t, logic [4:0] o);
        if (!o[4] && s.stalls < 65535) s.stalls++;
        if (!s.busy && br && s.flushes < 65535) s.flushes++;
        if (s.busy) begin
            if (md) s.busy = 0;
            else if (s.waited == t - 1) begin
                s.busy = 0;
                s.err = 1;
            end else s.waited++;
        end else if (!br && ms && !md) begin
            s.busy = 1;
            s.waited = 0;
        end
        return s;
    endfunction

    // inputs already driven just after a negedge; compare, then cross one posedge
    task automatic cyc(bit use_want = 0, logic [4:0] want = 5'b0);
        logic [4:0] o [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) m[i] = '{0, 0, 0, 0, 0};
            o[i] = expect_out(m[i], tmo[i]);
            if (use_want) chk($sformatf("d%0d vector", i), {pc[i], ifid[i], idex[i], ifl[i], idfl[i]}, want);
            chk($sformatf("d%0d pc_en", i), pc[i], o[i][4]);
            chk($sformatf("d%0d ifid_en", i), ifid[i], o[i][3]);
            chk($sformatf("d%0d idex_en", i), idex[i], o[i][2]);
            chk($sformatf("d%0d ifid_flush", i), ifl[i], o[i][1]);
            chk($sformatf("d%0d idex_flush", i), idfl[i], o[i][0]);
            chk($sformatf("d%0d mc_err", i), err[i], m[i].err);
            chk($sformatf("d%0d stall_cnt", i), sc[i], PERF ? m[i].stalls : 0);
            chk($sformatf("d%0d flush_cnt", i), fc[i], PERF ? m[i].flushes : 0);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++)
            if (!rst) m[i] = advance(m[i], tmo[i], o[i]);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rs1 = 0; rs2 = 0; us1 = 0; us2 = 0; rd = 0;
        mr = 0; rw = 0; br = 0; ms = 0; md = 0;
    endtask

    vec_t vecs [$];

    initial begin
        idle();
        rst = 1;
        for (int i = 0; i < 2; i++) m[i] = '{0, 0, 0, 0, 0};
        vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00011});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11100});
        vecs.push_back('{0, 0, 3, 0, 1, 3, 1, 1, 0, 0, 0, 5'b00101});
        vecs.push_back('{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 5'b11100});
        vecs.push_back('{0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 5'b00101});
        vecs.push_back('{0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 5'b11100});
        vecs.push_back('{0, 0, 3, 0, 1, 3, 0, 1, 0, 0, 0, 5'b11100});
        vecs.push_back('{0, 0, 3, 0, 1, 3, 1, 0, 0, 0, 0, 5'b11100});
        vecs.push_back('{0, 0, 3, 0, 1, 3, 1, 1, 1, 1, 0, 5'b11111});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11100});
        vecs.push_back('{0, 0, 3, 0, 1, 3, 1, 1, 0, 1, 1, 5'b11100});
        @(negedge clk);
        foreach (vecs[k]) begin
            rst = vecs[k].rst; rs1 = vecs[k].rs1; rs2 = vecs[k].rs2;
            us1 = vecs[k].us1; us2 = vecs[k].us2; rd = vecs[k].rd;
            mr = vecs[k].mr; rw = vecs[k].rw; br = vecs[k].br;
            ms = vecs[k].ms; md = vecs[k].md;
            cyc(1, vecs[k].want);
        end

        // multicycle op done 5 cycles after start; short instance times out meanwhile
        idle(); rst = 1; cyc();
        idle(); ms = 1; cyc(1, 5'b00000);
        idle();
        for (int i = 0; i < 3; i++) cyc();
        cyc();
        md = 1; cyc();
        idle();
        chk("mc stall_cnt", sc[0], PERF ? 5 : 0);
        chk("mc no err", err[0], 0);
        chk("timeout err", err[1], 1);
        cyc();
        chk("err sticky", err[1], 1);
        rst = 1; cyc();
        chk("err cleared", err[1], 0);

        // done lands exactly in the timeout cycle of the short instance
        idle(); ms = 1; cyc();
        idle();
        for (int i = 0; i < 3; i++) cyc();
        md = 1; cyc();
        idle(); cyc();
        chk("done beats timeout", err[1], 0);

        // reset mid-wait then a single-cycle op
        ms = 1; cyc();
        idle(); cyc(); cyc();
        rst = 1; cyc(1, 5'b00011);
        idle(); ms = 1; md = 1; cyc(1, 5'b11100);

        // branch counted once
        idle(); rst = 1; cyc();
        idle(); br = 1; ms = 1; rd = 3; rs1 = 3; us1 = 1; mr = 1; rw = 1; cyc(1, 5'b11111);
        idle(); cyc(1, 5'b11100);
        chk("flush_cnt", fc[0], PERF ? 1 : 0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            rs1 = 4'($urandom_range(0, 3)); rs2 = 4'($urandom_range(0, 3));
            rd = 4'($urandom_range(0, 3));
            us1 = 1'($urandom); us2 = 1'($urandom);
            mr = 1'($urandom); rw = 1'($urandom);
            br = ($urandom_range(0, 7) == 0);
            ms = ($urandom_range(0, 5) == 0);
            md = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core. Generates enable and flush controls for the PC register, the IF/ID register and the ID/EX register. Resolves taken-branch flushes, load-use stalls and multicycle EX operations. A watchdog aborts a multicycle operation that never completes.

## Interface
- REG_W, 4, register-index width of rs1/rs2/rd
- MC_TIMEOUT, 64, maximum MC_WAIT cycles before abort (≥2)
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  REG_W  source indices of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads that source
- ex_rd  in  REG_W  destination index of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_write  in  1  EX instruction writes ex_rd
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mc_start  in  1  EX holds a multicycle op (1-cycle pulse on entry)
- mc_done  in  1  multicycle unit result valid this cycle
- pc_en, ifid_en, idex_en  out  1  register load enables
- ifid_flush, idex_flush  out  1  synchronous clear-to-NOP of the register
- mc_err  out  1  sticky multicycle timeout flag
- stall_cnt, flush_cnt  out  16  performance counters (see Configuration)

## Operation
- States: RUN, MC_WAIT. Registered state; outputs are combinational from state and inputs.
- Default in RUN: pc_en=ifid_en=idex_en=1, flushes 0.
- Load-use hazard (lu): ex_mem_read & ex_reg_write & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN priority: ex_branch_taken > mc_start > lu.
  - Branch: ifid_flush=1, idex_flush=1, enables 1; stay RUN. mc_start and lu are ignored.
  - mc_start & !mc_done: pc_en=ifid_en=idex_en=0; next MC_WAIT, wait_cnt←0.
  - mc_start & mc_done: treated as single-cycle; default outputs.
  - lu: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1 (one bubble); stay RUN.
- MC_WAIT: pc_en=ifid_en=idex_en=0; ex_branch_taken, mc_start and lu are ignored.
  - mc_done: enables 1 in that same cycle; next RUN.
  - !mc_done & wait_cnt==MC_TIMEOUT-1: enables 1, idex_flush=1 (squash op); mc_err←1; next RUN.
  - Otherwise: wait_cnt increments.
  - mc_done and timeout in the same cycle: done wins, mc_err unchanged.
- wait_cnt width is $clog2(MC_TIMEOUT); no wrap is possible.
- mc_err is cleared only by rst.

## Timing
- While rst=1:
  - Outputs: pc_en=ifid_en=idex_en=0, ifid_flush=idex_flush=1.
  - Internal: state=RUN, wait_cnt=0, mc_err=0, counters=0.
- rst asserting mid-MC_WAIT: immediate return to RUN values; the pending op is discarded.
- Branch flush, load-use bubble and MC release take effect at the same edge the condition is sampled (zero-cycle decision latency).
- Load-use costs exactly 1 stall cycle.
- Multicycle op with done N cycles after mc_start (1≤N≤MC_TIMEOUT): stall of N cycles.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt counts cycles with rst=0 & pc_en=0.
  - flush_cnt counts RUN cycles with ex_branch_taken=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- PIPE_CTRL_PERF_EN undefined: counters not built; stall_cnt and flush_cnt are tied to 0. Ports are unchanged.

## Test plan
- Reset: rst=1 mid-cycle (async) -> outputs immediately 0/0/0/1/1. Release -> pc_en=ifid_en=idex_en=1, mc_err=0.
- Load-use:
  - ex_mem_read=1, ex_reg_write=1, ex_rd=3, id_rs2=3, id_uses_rs2=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle.
  - Same stimulus with ex_rd=0 -> no stall.
- Branch priority: ex_branch_taken=1 together with the load-use condition and mc_start=1 -> ifid_flush=idex_flush=1, all enables 1, state stays RUN, flush_cnt=1 (PERF_EN).
- Multicycle: mc_start pulse, mc_done 5 cycles later -> enables 0 for 5 cycles, 1 in the done cycle. stall_cnt=5 (PERF_EN, counted from mc_start cycle through the cycle before done); mc_err=0.
- Timeout: MC_TIMEOUT=4, mc_start, no mc_done -> after 4 MC_WAIT cycles: enables 1 and idex_flush=1 in the timeout cycle, mc_err=1 sticky. A later rst clears it.
- Done-vs-timeout and reset mid-wait:
  - mc_done in the timeout cycle -> RUN, mc_err stays 0.
  - rst pulse during MC_WAIT -> RUN; a following mc_start with mc_done=1 causes no stall.
